// File: rtl/vj_pkg.sv
// Shared Viola-Jones sequencer types: FSM state encoding, window geometry, score width derivation.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vj_pkg;

    // Detection window edge length in pixels, and its pixel count.
    localparam int VJ_WIN        = 19;
    localparam int VJ_WIN_PIXELS = VJ_WIN * VJ_WIN;

    // Stage sequencer states.
    typedef enum logic [1:0] {
        VJ_IDLE  = 2'd0,
        VJ_ISSUE = 2'd1,
        VJ_WAIT  = 2'd2,
        VJ_DONE  = 2'd3
    } vj_seq_state_t;

    // Accumulator width that cannot overflow when every weak classifier adds
    // a full-scale alpha: alpha width, plus log2 of the term count, plus one
    // guard bit so the signed sum never wraps.
    function automatic int vj_score_w(input int alpha_w, input int num_weak);
        return alpha_w + $clog2(num_weak) + 1;
    endfunction

endpackage

// File: rtl/vj_stage_sequencer.sv
// Sequences one boosted stage: walks NUM_WEAK weak classifiers, accumulates alpha votes, reports face/no-face.
// Latency: 2 cycles per weak classifier with an ideal evaluator; result pulse 2*NUM_WEAK+1 cycles after start.
// Backpressure: eval_ready low stretches ISSUE, late feat_valid stretches WAIT; one request outstanding, no timeout.
// Optional feature: define VJ_VOTE_TRACE_EN to add the per-weak vote_mask output.
module vj_stage_sequencer
    import vj_pkg::*;
#(
    parameter int NUM_WEAK = 16,
    parameter int THRESH_W = 32,
    parameter int ALPHA_W  = 16,
    parameter int SCORE_W  = vj_score_w(ALPHA_W, NUM_WEAK),
    localparam int IDX_W   = $clog2(NUM_WEAK)
) (
    input  logic                       clk,
    input  logic                       rst,
    // window scanner side
    input  logic                       start,
    input  logic                       abort,
    input  logic signed [SCORE_W-1:0]  stage_thresh,
    output logic                       busy,
    output logic                       result_valid,
    output logic                       result_face,
    output logic signed [SCORE_W-1:0]  result_score,
    // feature ROM (combinational lookup on rom_idx)
    output logic [IDX_W-1:0]           rom_idx,
    input  logic signed [THRESH_W-1:0] rom_threshold,
    input  logic signed [ALPHA_W-1:0]  rom_alpha,
    input  logic                       rom_polarity,
    // rectangle evaluator
    output logic                       eval_valid,
    input  logic                       eval_ready,
    output logic [IDX_W-1:0]           eval_idx,
    input  logic                       feat_valid,
    input  logic signed [THRESH_W-1:0] feat_value
`ifdef VJ_VOTE_TRACE_EN
    ,
    output logic [NUM_WEAK-1:0]        vote_mask
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WEAK - 1);

    vj_seq_state_t               state_q;
    logic [IDX_W-1:0]            idx_q;
    logic signed [SCORE_W-1:0]   score_q;
    logic signed [SCORE_W-1:0]   stage_thresh_q;

    // Weak classifier parameters captured when the evaluator accepts the
    // request, so the ROM index may move on without disturbing the vote.
    logic signed [THRESH_W-1:0]  thr_q;
    logic signed [ALPHA_W-1:0]   alpha_q;
    logic                        pol_q;

    logic                        vote;
    logic signed [SCORE_W-1:0]   alpha_ext;
    logic signed [SCORE_W-1:0]   score_next;
    logic                        last_weak;
    logic                        start_go;
    logic                        feat_take;

    // The ROM index and evaluator index are the same running counter.
    assign rom_idx      = idx_q;
    assign eval_idx     = idx_q;

    // Status and handshake outputs decode directly from the state.
    assign busy         = (state_q != VJ_IDLE);
    assign eval_valid   = (state_q == VJ_ISSUE);
    assign result_valid = (state_q == VJ_DONE);

    assign last_weak    = (idx_q == LAST_IDX);
    assign start_go     = (state_q == VJ_IDLE) && start;
    assign feat_take    = (state_q == VJ_WAIT) && feat_valid;

    // Weak vote: polarity 1 votes below threshold, polarity 0 above; a tie
    // never votes. The vote adds the sign-extended alpha to the running score.
    always_comb begin
        vote       = 1'b0;
        alpha_ext  = '0;
        score_next = score_q;
        if (pol_q) begin
            vote = (feat_value < thr_q);
        end else begin
            vote = (feat_value > thr_q);
        end
        alpha_ext  = {{(SCORE_W - ALPHA_W){alpha_q[ALPHA_W-1]}}, alpha_q};
        score_next = vote ? (score_q + alpha_ext) : score_q;
    end

    // Stage FSM, weak index walk, parameter capture and score accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= VJ_IDLE;
            idx_q          <= '0;
            score_q        <= '0;
            stage_thresh_q <= '0;
            thr_q          <= '0;
            alpha_q        <= '0;
            pol_q          <= 1'b0;
            result_face    <= 1'b0;
            result_score   <= '0;
        end else if (abort) begin
            // A vote arriving in the same cycle is dropped with the stage.
            state_q <= VJ_IDLE;
            idx_q   <= '0;
            score_q <= '0;
        end else begin
            unique case (state_q)
                VJ_IDLE: begin
                    if (start) begin
                        idx_q          <= '0;
                        score_q        <= '0;
                        stage_thresh_q <= stage_thresh;
                        state_q        <= VJ_ISSUE;
                    end
                end
                VJ_ISSUE: begin
                    if (eval_ready) begin
                        thr_q   <= rom_threshold;
                        alpha_q <= rom_alpha;
                        pol_q   <= rom_polarity;
                        state_q <= VJ_WAIT;
                    end
                end
                VJ_WAIT: begin
                    if (feat_valid) begin
                        score_q <= score_next;
                        if (last_weak) begin
                            result_face  <= (score_next >= stage_thresh_q);
                            result_score <= score_next;
                            state_q      <= VJ_DONE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= VJ_ISSUE;
                        end
                    end
                end
                VJ_DONE: begin
                    // Single-cycle result pulse; start is not looked at here.
                    state_q <= VJ_IDLE;
                end
                default: begin
                    state_q <= VJ_IDLE;
                end
            endcase
        end
    end

`ifdef VJ_VOTE_TRACE_EN
    // Per-weak vote record: cleared when a stage begins or is dropped, one bit
    // set per voting classifier, left untouched after the result until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            vote_mask <= '0;
        end else if (abort) begin
            vote_mask <= '0;
        end else if (start_go) begin
            vote_mask <= '0;
        end else if (feat_take && vote) begin
            vote_mask[idx_q] <= 1'b1;
        end
    end
`else
    // Without the trace output these decodes have no consumer.
    logic unused_trace;
    assign unused_trace = start_go ^ feat_take;
`endif

endmodule

// File: tb/tb_vj_stage_sequencer.sv
// Directed bench for vj_stage_sequencer with a 16-entry ROM table and a stallable evaluator model.
// Latency: checks the 33-cycle result timing and re-acceptance of start in cycle 34.
// Backpressure: drives configurable eval_ready stalls and delayed feat_valid.
module tb_vj_stage_sequencer;

    localparam int NW = 16;
    localparam int TW = 32;
    localparam int AW = 16;
    localparam int SW = AW + 4 + 1;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic signed [SW-1:0] stage_thresh;
    logic                 busy;
    logic                 result_valid;
    logic                 result_face;
    logic signed [SW-1:0] result_score;
    logic [3:0]           rom_idx;
    logic signed [TW-1:0] rom_threshold;
    logic signed [AW-1:0] rom_alpha;
    logic                 rom_polarity;
    logic                 eval_valid;
    logic                 eval_ready;
    logic [3:0]           eval_idx;
    logic                 feat_valid;
    logic signed [TW-1:0] feat_value;
`ifdef VJ_VOTE_TRACE_EN
    logic [NW-1:0]        vote_mask;
`endif

    int compared   = 0;
    int mismatched = 0;

    vj_stage_sequencer #(
        .NUM_WEAK (NW),
        .THRESH_W (TW),
        .ALPHA_W  (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .stage_thresh  (stage_thresh),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_face   (result_face),
        .result_score  (result_score),
        .rom_idx       (rom_idx),
        .rom_threshold (rom_threshold),
        .rom_alpha     (rom_alpha),
        .rom_polarity  (rom_polarity),
        .eval_valid    (eval_valid),
        .eval_ready    (eval_ready),
        .eval_idx      (eval_idx),
        .feat_valid    (feat_valid),
        .feat_value    (feat_value)
`ifdef VJ_VOTE_TRACE_EN
        ,
        .vote_mask     (vote_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Feature ROM: thresholds spread around zero, polarity pattern 0xB2D8.
    // Polarity-1 alphas sum to 1645, polarity-0 alphas (one negative) to 1677.
    logic signed [TW-1:0] thr_tab   [NW];
    logic signed [AW-1:0] alpha_tab [NW];
    logic [NW-1:0]        pol_bits;

    assign rom_threshold = thr_tab[rom_idx];
    assign rom_alpha     = alpha_tab[rom_idx];
    assign rom_polarity  = pol_bits[rom_idx];

    // Evaluator model: ready after rdy_lat stalled cycles, answer feat_lat cycles after acceptance.
    int         rdy_lat = 0;
    int         feat_lat = 1;
    int         mode = 0;
    int         wcnt = 0;
    int         fcnt = 0;
    logic       pend = 1'b0;
    logic [3:0] fidx = '0;

    assign eval_ready = eval_valid && (wcnt >= rdy_lat);
    assign feat_valid = pend && (fcnt == 1);

    always_comb begin
        feat_value = '0;
        case (mode)
            0:       feat_value = -32'sd1000;
            1:       feat_value = 32'sd1000;
            default: feat_value = thr_tab[fidx];
        endcase
    end

    always @(posedge clk) begin
        if (rst || abort) begin
            wcnt <= 0;
            pend <= 1'b0;
            fcnt <= 0;
        end else begin
            if (eval_valid && !eval_ready) wcnt <= wcnt + 1;
            else wcnt <= 0;
            if (eval_valid && eval_ready) begin
                pend <= 1'b1;
                fcnt <= feat_lat;
                fidx <= eval_idx;
            end else if (pend) begin
                if (fcnt == 1) pend <= 1'b0;
                else fcnt <= fcnt - 1;
            end
        end
    end

    // Bookkeeping: stall hold-stability, stall cycle count, result pulse count.
    int         stall_viol = 0;
    int         stall_cnt  = 0;
    int         rv_count   = 0;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_idx   = '0;

    always @(posedge clk) begin
        if (prev_stall && !(eval_valid && eval_idx == prev_idx)) stall_viol++;
        prev_stall <= eval_valid && !eval_ready && !abort && !rst;
        prev_idx   <= eval_idx;
        if (eval_valid && !eval_ready) stall_cnt++;
        if (result_valid) rv_count++;
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Launch a stage, optionally change stage_thresh after it is sampled and
    // pulse start again at cycle pulse_at; return the cycle of result_valid.
    task automatic run_stage(input logic signed [SW-1:0] thr, input logic signed [SW-1:0] late_thr,
                             input int pulse_at, output int cyc);
        stage_thresh = thr;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stage_thresh = late_thr;
        cyc = 1;
        while (!result_valid && cyc < 400) begin
            start = (cyc == pulse_at);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    int cyc;
    int rv_before;
    int stall_before;
    int found;

    initial begin
        for (int k = 0; k < NW; k++) thr_tab[k] = (k - 8) * 50;
        alpha_tab[0]  = 310;  alpha_tab[1]  = -100; alpha_tab[2]  = 220; alpha_tab[3]  = 200;
        alpha_tab[4]  = 210;  alpha_tab[5]  = 190;  alpha_tab[6]  = 190; alpha_tab[7]  = 205;
        alpha_tab[8]  = 230;  alpha_tab[9]  = 215;  alpha_tab[10] = 205; alpha_tab[11] = 211;
        alpha_tab[12] = 195;  alpha_tab[13] = 220;  alpha_tab[14] = 411; alpha_tab[15] = 210;
        pol_bits = 16'b1011_0010_1101_1000;

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        stage_thresh = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_eval_valid", eval_valid, 0);
        check("reset_result_valid", result_valid, 0);
        check("reset_result_face", result_face, 0);
        check("reset_result_score", result_score, 0);
        check("reset_rom_idx", rom_idx, 0);
`ifdef VJ_VOTE_TRACE_EN
        check("reset_vote_mask", vote_mask, 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Negative features: only polarity-1 entries vote.
        mode = 0;
        run_stage(1661, 1661, 0, cyc);
        check("neg_cycle", cyc, 33);
        check("neg_score", result_score, 1645);
        check("neg_face", result_face, 0);
`ifdef VJ_VOTE_TRACE_EN
        check("neg_vote_mask", vote_mask, 16'hB2D8);
`endif
        @(posedge clk);
        #1;
        check("neg_pulse_one_cycle", result_valid, 0);
        check("neg_idle_cycle34", busy, 0);

        // Positive features, started in cycle 34; threshold changed after capture.
        mode = 1;
        run_stage(1661, 5000, 0, cyc);
        check("pos_cycle", cyc, 33);
        check("pos_score", result_score, 1677);
        check("pos_face", result_face, 1);
`ifdef VJ_VOTE_TRACE_EN
        check("pos_vote_mask", vote_mask, 16'h4D27);
`endif
        @(posedge clk);
        #1;

        // Feature equals each weak threshold: no votes, score 0.
        mode = 2;
        run_stage(0, 0, 0, cyc);
        check("eq_t0_score", result_score, 0);
        check("eq_t0_face", result_face, 1);
        @(posedge clk);
        #1;
        run_stage(1, 1, 0, cyc);
        check("eq_t1_score", result_score, 0);
        check("eq_t1_face", result_face, 0);
        @(posedge clk);
        #1;

        // Stalled handshakes: 5 cycles of eval_ready low, feat_valid 3 cycles late.
        mode = 0;
        rdy_lat = 5;
        feat_lat = 4;
        stall_before = stall_cnt;
        rv_before = rv_count;
        run_stage(1661, 1661, 0, cyc);
        check("stall_reached_result", result_valid, 1);
        check("stall_score", result_score, 1645);
        check("stall_face", result_face, 0);
        @(posedge clk);
        #1;
        check("stall_hold_violations", stall_viol, 0);
        check("stall_cycles", stall_cnt - stall_before, 80);
        check("stall_result_pulses", rv_count - rv_before, 1);
        rdy_lat = 0;
        feat_lat = 1;

        // Abort while waiting on weak 7, coincident with its feat_valid.
        mode = 1;
        stage_thresh = 1661;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (busy && !eval_valid && eval_idx == 4'd7) found = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("abort_found_wait7", found, 1);
        rv_before = rv_count;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy_low", busy, 0);
`ifdef VJ_VOTE_TRACE_EN
        check("abort_vote_mask", vote_mask, 0);
`endif
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_result", rv_count - rv_before, 0);

        // Fresh stage after abort, with a start pulsed mid-stage that must be ignored.
        mode = 1;
        run_stage(1661, 1661, 10, cyc);
        check("restart_cycle", cyc, 33);
        check("restart_score", result_score, 1677);
        check("restart_face", result_face, 1);
        @(posedge clk);
        #1;

        // Reset in the middle of a stage clears every output.
        mode = 0;
        stage_thresh = 1661;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("midrst_idx_moved", (rom_idx != 0), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_eval_valid", eval_valid, 0);
        check("midrst_result_valid", result_valid, 0);
        check("midrst_result_face", result_face, 0);
        check("midrst_result_score", result_score, 0);
        check("midrst_rom_idx", rom_idx, 0);
        check("midrst_eval_idx", eval_idx, 0);
`ifdef VJ_VOTE_TRACE_EN
        check("midrst_vote_mask", vote_mask, 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
